// File: rtl/tile_lookup_arbiter.sv
// Round-robin arbiter that serialises actor tile lookups onto one map RAM read port.
// Coordinates on or outside the border answer "wall" without touching the RAM.
module tile_lookup_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BORDER_X_MIN = 1,
    parameter int unsigned BORDER_X_MAX = 28,
    parameter int unsigned BORDER_Y_MIN = 1,
    parameter int unsigned BORDER_Y_MAX = 28
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [5*NUM_REQ-1:0]   i_req_x,
    input  logic [5*NUM_REQ-1:0]   i_req_y,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic                   o_rsp_wall,
    output logic                   o_map_rd_en,
    output logic [9:0]             o_map_addr,
    input  logic                   i_map_rdata,
    output logic                   o_busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [IDX_W-1:0]     r_last_winner;
    logic                 r_force_wall;
    logic [9:0]           r_map_addr;

    logic [NUM_REQ-1:0]   w_cur_onehot;
    logic [NUM_REQ-1:0]   w_req_masked;
    logic [31:0]          w_cand;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_found;
    logic                 w_arb_fire;
    logic [4:0]           w_win_x;
    logic [4:0]           w_win_y;
    logic                 w_force_wall;

    // r_last_winner doubles as the index of the lookup currently in flight.
    always_comb begin
        w_cur_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_last_winner == IDX_W'(k)) begin
                w_cur_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_req_masked = i_req & ~((r_state == StResp) ? w_cur_onehot : '0);
        w_win_found  = 1'b0;
        w_win_idx    = r_last_winner;
        w_cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_cand = (32'(r_last_winner) + i) % NUM_REQ;
            if (!w_win_found && w_req_masked[w_cand[IDX_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_x = '0;
        w_win_y = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win_idx == IDX_W'(k)) begin
                w_win_x = i_req_x[5*k +: 5];
                w_win_y = i_req_y[5*k +: 5];
            end
        end
    end

    assign w_force_wall = !((w_win_x > 5'(BORDER_X_MIN)) && (w_win_x < 5'(BORDER_X_MAX)) &&
                            (w_win_y > 5'(BORDER_Y_MIN)) && (w_win_y < 5'(BORDER_Y_MAX)));

    assign w_arb_fire = ((r_state == StIdle) || (r_state == StResp)) && w_win_found;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_last_winner <= IDX_W'(NUM_REQ - 1);
            r_force_wall  <= 1'b0;
            r_map_addr    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_arb_fire) begin
                r_last_winner <= w_win_idx;
                r_force_wall  <= w_force_wall;
                r_map_addr    <= {w_win_y, w_win_x};
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_gnt        = '0;
        o_rsp_valid  = '0;
        o_rsp_wall   = 1'b0;
        o_map_rd_en  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_win_found) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                o_gnt        = w_cur_onehot;
                o_map_rd_en  = !r_force_wall;
                w_state_next = StResp;
            end
            StResp: begin
                o_rsp_valid  = w_cur_onehot;
                o_rsp_wall   = r_force_wall | i_map_rdata;
                w_state_next = w_win_found ? StRead : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_map_addr = r_map_addr;
    assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_tile_lookup_arbiter.sv
// Directed bench for tile_lookup_arbiter: single lookup, border walls, round-robin,
// fairness, abandoned request and reset during a lookup.
module tb_tile_lookup_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [19:0] req_x;
    logic [19:0] req_y;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic        rsp_wall;
    logic        map_rd_en;
    logic [9:0]  map_addr;
    logic        map_rdata;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    tile_lookup_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .o_gnt       (gnt),
        .o_rsp_valid (rsp_valid),
        .o_rsp_wall  (rsp_wall),
        .o_map_rd_en (map_rd_en),
        .o_map_addr  (map_addr),
        .i_map_rdata (map_rdata),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_xy(input int idx, input logic [4:0] x, input logic [4:0] y);
        req_x[5*idx +: 5] = x;
        req_y[5*idx +: 5] = y;
    endtask

    // One complete lookup by requester 1 starting from IDLE.
    task automatic lookup1(input string tag, input logic [4:0] x, input logic [4:0] y,
                           input logic rdata, input logic exp_rd, input logic exp_wall);
        set_xy(1, x, y);
        req       = 4'b0010;
        map_rdata = rdata;
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'h2);
        chk({tag, "_rd_en"}, 32'(map_rd_en), 32'(exp_rd));
        chk({tag, "_addr"}, 32'(map_addr), 32'({y, x}));
        req = 4'b0000;
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h2);
        chk({tag, "_rsp_wall"}, 32'(rsp_wall), 32'(exp_wall));
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_x     = '0;
        req_y     = '0;
        map_rdata = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_wall", 32'(rsp_wall), 32'h0);
        chk("rst_rd_en", 32'(map_rd_en), 32'h0);
        chk("rst_addr", 32'(map_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Single lookup, requester 0 at (5,7)
        set_xy(0, 5'd5, 5'd7);
        req       = 4'b0001;
        map_rdata = 1'b1;
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_rd_en", 32'(map_rd_en), 32'h1);
        chk("single_addr", 32'(map_addr), 32'h0E5);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_no_rsp_in_read", 32'(rsp_valid), 32'h0);
        req = 4'b0000;
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_wall", 32'(rsp_wall), 32'h1);
        chk("single_no_gnt_in_resp", 32'(gnt), 32'h0);
        map_rdata = 1'b0;
        #1;
        chk("single_rsp_open", 32'(rsp_wall), 32'h0);
        tick();
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_addr_hold", 32'(map_addr), 32'h0E5);
        chk("single_idle_rsp", 32'(rsp_valid), 32'h0);

        // Border and near-border lookups by requester 1
        lookup1("bx_min", 5'd1, 5'd10, 1'b0, 1'b0, 1'b1);
        lookup1("bx_max", 5'd28, 5'd10, 1'b0, 1'b0, 1'b1);
        lookup1("by_max", 5'd10, 5'd28, 1'b0, 1'b0, 1'b1);
        lookup1("by_min", 5'd10, 5'd1, 1'b1, 1'b0, 1'b1);
        lookup1("inside_open", 5'd2, 5'd27, 1'b0, 1'b1, 1'b0);
        lookup1("inside_wall", 5'd27, 5'd2, 1'b1, 1'b1, 1'b1);
        lookup1("outside", 5'd30, 5'd10, 1'b0, 1'b0, 1'b1);

        // Round-robin from a fresh reset: all four held, each drops after its grant
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_xy(i, 5'd10, 5'd10);
        map_rdata = 1'b0;
        req       = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << k));
            chk($sformatf("rr_busy_read%0d", k), 32'(busy), 32'h1);
            req[k] = 1'b0;
            tick();
            chk($sformatf("rr_rsp%0d", k), 32'(rsp_valid), 32'(1 << k));
            chk($sformatf("rr_busy_resp%0d", k), 32'(busy), 32'h1);
        end
        tick();
        chk("rr_done_idle", 32'(busy), 32'h0);

        // Fairness: 0 and 2 held high alternate
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fair_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h4);
            if (k == 3) req = 4'b0000;
            tick();
            chk($sformatf("fair_rsp%0d", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h4);
        end
        tick();
        chk("fair_idle", 32'(busy), 32'h0);

        // Abandon: req[3] pulses only during requester 1's READ cycle
        req = 4'b0010;
        tick();
        chk("abn_gnt1", 32'(gnt), 32'h2);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        chk("abn_rsp1", 32'(rsp_valid), 32'h2);
        chk("abn_no_gnt_resp", 32'(gnt), 32'h0);
        tick();
        chk("abn_no_gnt3", 32'(gnt), 32'h0);
        chk("abn_no_rsp3", 32'(rsp_valid), 32'h0);
        chk("abn_idle", 32'(busy), 32'h0);
        tick();
        chk("abn_no_gnt3_late", 32'(gnt), 32'h0);

        // Reset asserted during READ of requester 2
        req = 4'b0100;
        tick();
        chk("rmid_gnt2", 32'(gnt), 32'h4);
        req   = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("rmid_gnt0", 32'(gnt), 32'h0);
        chk("rmid_rd_en0", 32'(map_rd_en), 32'h0);
        chk("rmid_addr0", 32'(map_addr), 32'h0);
        chk("rmid_busy0", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rmid_no_rsp", 32'(rsp_valid), 32'h0);
        chk("rmid_no_wall", 32'(rsp_wall), 32'h0);
        chk("rmid_idle", 32'(busy), 32'h0);
        // Without the reset index 3 would follow winner 2; after it index 0 must win.
        req = 4'b1001;
        tick();
        chk("rmid_next_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("rmid_next_rsp", 32'(rsp_valid), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_lookup_arbiter.md
TILE_LOOKUP_ARBITER -- requirements
Module: tile_lookup_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of actor requesters; index 0 is Pacman, 1..3 are ghosts.
REQ-002 Parameter: BORDER_X_MIN, default 1, lowest x treated as wall.
REQ-003 Parameter: BORDER_X_MAX, default 28, highest x treated as wall.
REQ-004 Parameter: BORDER_Y_MIN, default 1, lowest y treated as wall.
REQ-005 Parameter: BORDER_Y_MAX, default 28, highest y treated as wall.
REQ-006 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-007 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port: req  input  NUM_REQ  per-actor lookup request, level; held until gnt.
REQ-009 Port: req_x  input  5*NUM_REQ  tile x of each requester; slice i is bits [5i+4:5i].
REQ-010 Port: req_y  input  5*NUM_REQ  tile y of each requester; same packing.
REQ-011 Port: gnt  output  NUM_REQ  one-hot, one-cycle pulse: request accepted.
REQ-012 Port: rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse: result on rsp_wall.
REQ-013 Port: rsp_wall  output  1  lookup result; 1 = wall or outside border.
REQ-014 Port: map_rd_en  output  1  map RAM read strobe.
REQ-015 Port: map_addr  output  10  map RAM address {y[4:0], x[4:0]}.
REQ-016 Port: map_rdata  input  1  map RAM data; valid the cycle after map_rd_en.
REQ-017 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, READ, RESP; encoding free.
REQ-019 Arbitration occurs in IDLE and in RESP; if any unmasked req bit is set, next state is READ, else IDLE.
REQ-020 Winner: round-robin; search starts at index (last_winner+1) mod NUM_REQ, wraps; last_winner resets to NUM_REQ-1, so index 0 wins first.
REQ-021 In RESP, the requester being answered is masked from arbitration.
REQ-022 Winner index and its x/y are registered at the arbitration edge; later req_x/req_y changes do not affect the lookup in flight.
REQ-023 READ (one cycle): gnt[winner]=1; map_addr={y,x} of winner; map_rd_en=1 only if BORDER_X_MIN < x < BORDER_X_MAX and BORDER_Y_MIN < y < BORDER_Y_MAX; otherwise map_rd_en=0 and result is forced wall.
REQ-024 READ always transitions to RESP.
REQ-025 RESP (one cycle): rsp_valid[winner]=1; rsp_wall = forced-wall flag OR map_rdata.
REQ-026 Latency: req seen in IDLE at edge N -> gnt in cycle N+1 -> rsp_valid in cycle N+2; back-to-back lookups every 2 cycles.
REQ-027 Outside READ: gnt=0, map_rd_en=0, map_addr holds last value; outside RESP: rsp_valid=0, rsp_wall=0.
REQ-028 Requester dropping req before gnt: request is abandoned, no gnt, no rsp.
REQ-029 Boundary coordinates (x or y equal to a MIN/MAX value) are walls; comparisons are unsigned 5-bit.
REQ-030 gnt and rsp_valid are never asserted for more than one bit or for more than one cycle per lookup.

Reset
REQ-031 rst_n low asynchronously forces IDLE; gnt=0, rsp_valid=0, rsp_wall=0, map_rd_en=0, map_addr=0, busy=0, last_winner=NUM_REQ-1.
REQ-032 Reset asserted in READ or RESP aborts the lookup; no rsp_valid is produced after release.
REQ-033 First arbitration occurs on the first rising edge with rst_n high.

Verification
REQ-034 Single lookup: req=0001, x=5, y=7, map_rdata=1 -> gnt=0001 next cycle, map_rd_en=1, map_addr=0x0E5; following cycle rsp_valid=0001, rsp_wall=1.
REQ-035 Border: req=0010, slice 1 x=1, y=10 -> READ with map_rd_en=0, gnt=0010; RESP rsp_wall=1 regardless of map_rdata; also x=28 and y=28 give wall.
REQ-036 Round-robin: req=1111 held, each requester drops req after its gnt -> gnt order 0001,0010,0100,1000, gnt every 2 cycles, busy high throughout.
REQ-037 Fairness: req[0] and req[2] permanently high -> grants alternate 0,2,0,2; neither is granted twice in a row.
REQ-038 Reset mid-op: rst_n low during READ for one cycle -> all outputs 0 immediately, no rsp_valid after release, next grant goes to index 0.
REQ-039 Abandon: req[3] high one cycle while index 1 is in service, then low -> no gnt[3], no rsp_valid[3].
